nrisc_mul_seq: RTL and testbench



---
 rtl/nrisc_ula_pkg.sv | 35 +++
 rtl/NRISC_ULA.sv | 51 +++++
 rtl/nrisc_mul_seq.sv | 124 ++++++++++++
 tb/tb_nrisc_mul_seq.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/nrisc_ula_pkg.sv
// Shared NRISC ALU definitions: command codes, flag bit positions, multiplier states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nrisc_ula_pkg;

    // ALU command codes {cmd, func}; cmd=1 selects the rotate variants
    localparam logic [3:0] ULA_ADD = 4'b0000;
    localparam logic [3:0] ULA_SUB = 4'b0001;
    localparam logic [3:0] ULA_AND = 4'b0010;
    localparam logic [3:0] ULA_OR  = 4'b0011;
    localparam logic [3:0] ULA_XOR = 4'b0100;
    localparam logic [3:0] ULA_SHR = 4'b0101;
    localparam logic [3:0] ULA_SHL = 4'b0110;
    localparam logic [3:0] ULA_NOT = 4'b0111;
    localparam logic [3:0] ULA_ROR = 4'b1101;
    localparam logic [3:0] ULA_ROL = 4'b1110;

    // Bit positions inside the {minus, zero, carry} flag vector
    localparam int FLG_CARRY = 0;
    localparam int FLG_ZERO  = 1;
    localparam int FLG_MINUS = 2;

    // Sequencer states of the shift-and-add multiplier
    typedef enum logic [2:0] {
        S_IDLE,
        S_SHR_I,
        S_SHR_C,
        S_ADD_I,
        S_ADD_C,
        S_SHL_I,
        S_SHL_C,
        S_DONE
    } mul_state_t;

endpackage

// File: rtl/NRISC_ULA.sv
// NRISC ALU: add/sub/logic/shift/rotate on A,B with {minus, zero, carry} flags.
// Latency: 1 cycle, result and flags registered on the edge after the command is driven.
// Backpressure: none, accepts a command every cycle; synchronous active-low reset.
module NRISC_ULA
    import nrisc_ula_pkg::*;
#(
    parameter int TAM = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [TAM-1:0] A,
    input  logic [TAM-1:0] B,
    input  logic [3:0]     ctrl,
    output logic [TAM-1:0] OUT,
    output logic [2:0]     flags
);

    logic [TAM-1:0] res;
    logic           cy;

    // Combinational operation decode; carry is the add/sub carry or the bit shifted out
    always_comb begin
        res = '0;
        cy  = 1'b0;
        case (ctrl)
            ULA_ADD: {cy, res} = {1'b0, A} + {1'b0, B};
            ULA_SUB: {cy, res} = {1'b0, A} - {1'b0, B};
            ULA_AND: res = A & B;
            ULA_OR:  res = A | B;
            ULA_XOR: res = A ^ B;
            ULA_NOT: res = ~A;
            ULA_SHR: begin res = {A[TAM-1], A[TAM-1:1]}; cy = A[0];     end
            ULA_SHL: begin res = {A[TAM-2:0], 1'b0};     cy = A[TAM-1]; end
            ULA_ROR: begin res = {A[0], A[TAM-1:1]};     cy = A[0];     end
            ULA_ROL: begin res = {A[TAM-2:0], A[TAM-1]}; cy = A[TAM-1]; end
            default: begin res = '0; cy = 1'b0; end
        endcase
    end

    // Register result and flags one clock after issue
    always_ff @(posedge clk) begin
        if (!rst) begin
            OUT   <= '0;
            flags <= '0;
        end else begin
            OUT   <= res;
            flags <= {res[TAM-1], (res == '0), cy};
        end
    end

endmodule

// File: rtl/nrisc_mul_seq.sv
// Iterative shift-and-add multiplier driving the NRISC ALU; returns low TAM bits of op_a*op_b.
// Latency: 4*TAM+1+2*popcount(op_b) cycles from start to the done pulse.
// Backpressure: start is taken only in IDLE; requests while busy are dropped, never queued.
module nrisc_mul_seq
    import nrisc_ula_pkg::*;
#(
    parameter int TAM = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [TAM-1:0] op_a,
    input  logic [TAM-1:0] op_b,
    output logic           busy,
    output logic           done,
    output logic [TAM-1:0] result,
    output logic [TAM-1:0] ULA_A,
    output logic [TAM-1:0] ULA_B,
    output logic [3:0]     ULA_ctrl,
    input  logic [TAM-1:0] ULA_OUT,
    input  logic [2:0]     ULA_flags
);

    localparam int              IW        = $clog2(TAM);
    localparam logic [IW-1:0]   ITER_LAST = IW'(TAM - 1);

    mul_state_t     state;
    logic [TAM-1:0] mcand;
    logic [TAM-1:0] mplr;
    logic [TAM-1:0] acc;
    logic           bit_q;
    logic [IW-1:0]  iter;

    // Only the carry flag steers the sequence; minus/zero are deliberately ignored
    logic unused_flags;
    assign unused_flags = ^ULA_flags[FLG_MINUS:FLG_ZERO];

    // Sequencer: one ALU op per issue/capture pair, TAM iterations of shr / [add] / shl
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            mcand  <= '0;
            mplr   <= '0;
            acc    <= '0;
            bit_q  <= 1'b0;
            iter   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand <= op_a;
                        mplr  <= op_b;
                        acc   <= '0;
                        iter  <= '0;
                        busy  <= 1'b1;
                        state <= S_SHR_I;
                    end
                end
                S_SHR_I: state <= S_SHR_C;
                S_SHR_C: begin
                    // Bit shifted out of the multiplier is original op_b bit 'iter'
                    mplr  <= ULA_OUT;
                    bit_q <= ULA_flags[FLG_CARRY];
                    state <= ULA_flags[FLG_CARRY] ? S_ADD_I : S_SHL_I;
                end
                S_ADD_I: state <= S_ADD_C;
                S_ADD_C: begin
                    acc   <= ULA_OUT;
                    state <= S_SHL_I;
                end
                S_SHL_I: state <= S_SHL_C;
                S_SHL_C: begin
                    mcand <= ULA_OUT;
                    iter  <= iter + 1'b1;
                    if (iter == ITER_LAST) begin
                        // acc is final here, so publish it together with the done pulse
                        result <= acc;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        state <= S_SHR_I;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ALU drive decode: operands only in issue states, everything else reads zero
    always_comb begin
        ULA_A    = '0;
        ULA_B    = '0;
        ULA_ctrl = ULA_ADD;
        case (state)
            S_SHR_I: begin
                ULA_A    = mplr;
                ULA_ctrl = ULA_SHR;
            end
            S_ADD_I: begin
                ULA_A    = acc;
                ULA_B    = mcand;
                ULA_ctrl = ULA_ADD;
            end
            S_SHL_I: begin
                ULA_A    = mcand;
                ULA_ctrl = ULA_SHL;
            end
            default: ;
        endcase
    end

    // An add may only be issued when the captured multiplier bit was set
    add_needs_bit: assert property (@(posedge clk) disable iff (!rst)
        (state == S_ADD_I) |-> bit_q);

endmodule

// File: tb/tb_nrisc_mul_seq.sv
// Bench for nrisc_mul_seq wired to NRISC_ULA: directed runs plus a per-cycle arithmetic model.
// Latency: n/a.
// Backpressure: n/a.
module tb_nrisc_mul_seq;
    import nrisc_ula_pkg::*;

    localparam int TAM = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [TAM-1:0] op_a;
    logic [TAM-1:0] op_b;
    logic           busy;
    logic           done;
    logic [TAM-1:0] result;
    logic [TAM-1:0] ULA_A;
    logic [TAM-1:0] ULA_B;
    logic [3:0]     ULA_ctrl;
    logic [TAM-1:0] ULA_OUT;
    logic [2:0]     ULA_flags;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    nrisc_mul_seq #(.TAM(TAM)) dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .result(result),
        .ULA_A(ULA_A), .ULA_B(ULA_B), .ULA_ctrl(ULA_ctrl),
        .ULA_OUT(ULA_OUT), .ULA_flags(ULA_flags)
    );

    NRISC_ULA #(.TAM(TAM)) u_ula (
        .clk(clk), .rst(rst), .A(ULA_A), .B(ULA_B), .ctrl(ULA_ctrl),
        .OUT(ULA_OUT), .flags(ULA_flags)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] sra16(input logic [15:0] v, input int n);
        logic signed [15:0] s;
        s = v;
        return 16'(s >>> n);
    endfunction

    // Partial product after the first i multiplier bits: a * (b mod 2^i), mod 2^16
    function automatic logic [15:0] partial(input logic [15:0] a, input logic [15:0] b, input int i);
        logic [31:0] mask;
        logic [31:0] p;
        mask = (32'd1 << i) - 32'd1;
        p = {16'd0, a} * ({16'd0, b} & mask);
        return p[15:0];
    endfunction

    // ---------------- behavioural model + per-cycle compare ----------------
    bit             m_act = 1'b0;
    int             m_t0, m_td, m_nshr, m_nshl;
    logic [15:0]    m_a, m_b, m_pend;
    logic [15:0]    m_res = '0;
    bit             e_busy, e_done;

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_result", result, 0);
            chk("rst_ula", {ULA_A, ULA_B, ULA_ctrl}, 0);
            m_act = 1'b0;
            m_res = '0;
        end else if (rst === 1'b1) begin
            e_busy = m_act && cyc > m_t0 && cyc <= m_td;
            e_done = m_act && cyc == m_td;
            if (e_done) m_res = m_pend;
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("result", result, m_res);
            if (!e_busy) begin
                chk("ula_idle", {ULA_A, ULA_B, ULA_ctrl}, 0);
            end else begin
                case (ULA_ctrl)
                    ULA_SHR: begin
                        chk("shr_A", ULA_A, sra16(m_b, m_nshr));
                        chk("shr_B", ULA_B, 0);
                        m_nshr++;
                    end
                    ULA_SHL: begin
                        chk("shl_A", ULA_A, 16'(m_a << m_nshl));
                        chk("shl_B", ULA_B, 0);
                        m_nshl++;
                    end
                    ULA_ADD: begin
                        if ({ULA_A, ULA_B} != '0) begin
                            chk("add_bit", m_b[m_nshl & 15], 1);
                            chk("add_A", ULA_A, partial(m_a, m_b, m_nshl));
                            chk("add_B", ULA_B, 16'(m_a << m_nshl));
                        end
                    end
                    default: chk("ula_ctrl", ULA_ctrl, ULA_SHR);
                endcase
            end
            if (e_done) begin
                chk("n_shr", m_nshr, TAM);
                chk("n_shl", m_nshl, TAM);
            end
            if ((!m_act || cyc > m_td) && start === 1'b1) begin
                m_act  = 1'b1;
                m_t0   = cyc;
                m_td   = cyc + 4 * TAM + 1 + 2 * $countones(op_b);
                m_pend = op_a * op_b;
                m_a    = op_a;
                m_b    = op_b;
                m_nshr = 0;
                m_nshl = 0;
            end
        end
    end

    // ---------------- directed runs with hand-computed expectations ----------------
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int pulse_at,
                          input int exp_off, input logic [15:0] exp_res, input string nm);
        int  t0;
        int  dc;
        int  n_done;
        bit  got;
        logic busy_after;
        @(posedge clk); #1;
        op_a = a; op_b = b; start = 1'b1; t0 = cyc;
        got = 1'b0; dc = 0; n_done = 0; busy_after = 1'bx;
        for (int i = 1; i <= 150; i++) begin
            @(posedge clk); #1;
            start = (pulse_at > 0 && cyc == t0 + pulse_at);
            @(negedge clk);
            if (got && cyc == dc + 1) busy_after = busy;
            if (done === 1'b1) begin
                n_done++;
                if (!got) begin
                    got = 1'b1;
                    dc  = cyc;
                    chk({nm, "_result"}, result, exp_res);
                end
            end
        end
        chk({nm, "_seen"}, got, 1);
        chk({nm, "_latency"}, dc - t0, exp_off);
        chk({nm, "_ndone"}, n_done, 1);
        chk({nm, "_busy_after"}, busy_after, 0);
    endtask

    initial begin
        int t0;
        rst = 1'b0; start = 1'b0; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("init_busy", busy, 0);
        chk("init_result", result, 0);
        rst = 1'b1;

        run_op(16'd3,      16'd5,      0,  69, 16'd15,     "mul3x5");
        run_op(16'h1234,   16'h0000,   0,  65, 16'h0000,   "mul_b0");
        run_op(16'hFFFF,   16'hFFFF,   0,  97, 16'h0001,   "mul_ffff");
        run_op(16'h0002,   16'h8000,   0,  67, 16'h0000,   "mul_msb");
        run_op(16'd3,      16'd5,      10, 69, 16'd15,     "restart_ignored");

        // Reset mid-operation, then a fresh run
        @(posedge clk); #1;
        op_a = 16'd3; op_b = 16'd5; start = 1'b1; t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < t0 + 20) @(posedge clk);
        #1;
        chk("pre_rst_busy", busy, 1);
        rst = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_result", result, 0);
        chk("midrst_ula", {ULA_A, ULA_B, ULA_ctrl}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        run_op(16'd7,      16'd6,      0,  69, 16'd42,     "after_rst");
        run_op(16'h0101,   16'h00F0,   0,  73, 16'hF0F0,   "mul_mix");

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, %0d compared / %0d mismatched", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
